fht_stream_ctrl: RTL

Streaming front/back-end for the FHT core.
- Accepts ADC samples on a valid/ready input stream and sign-extends them.
- Distributes samples round-robin across N_BANK RAM(A) banks, then pulses start.
- Waits for the transform to finish, then reads results back and emits them as a valid/ready output stream in natural index order.
- Sits between the ADC/DMA side and the core's load/read ports, replacing the hand-driven iWE_x/iADDR_WR/iADDR_RD_x/iSTART interface with per-bank generality.

---
 rtl/fht_defines.sv | 17 +
 rtl/fht_stream_ser.sv | 50 +++++
 rtl/fht_stream_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fht_defines.sv
// Shared defaults and FSM encoding for the FHT streaming front/back-end.
package fht_defines;
    localparam int DEF_D_BIT  = 17;
    localparam int DEF_A_BIT  = 9;
    localparam int DEF_N_BANK = 4;
    localparam int DEF_RD_LAT = 1;
    localparam int LOG2_BANK  = $clog2(DEF_N_BANK);
    localparam int N          = DEF_N_BANK << DEF_A_BIT;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_UNLOAD
    } state_t;
endpackage

// File: rtl/fht_stream_ser.sv
// Hold register for one row of bank words, serialised lane by lane on a
// valid/ready stream.
module fht_stream_ser
    import fht_defines::*;
#(
    parameter int D_BIT  = DEF_D_BIT,
    parameter int N_BANK = DEF_N_BANK
)(
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iLOAD,
    input  logic [N_BANK*D_BIT-1:0] iWORDS,
    input  logic                    iREADY,
    output logic [D_BIT-1:0]        oDATA,
    output logic                    oVALID,
    output logic                    oEMPTY
);
    localparam int LOG2B = $clog2(N_BANK);
    localparam logic [LOG2B-1:0] LANE_LAST = LOG2B'(N_BANK - 1);

    logic [N_BANK*D_BIT-1:0] r_hold;
    logic [LOG2B-1:0]        r_lane;
    logic                    r_valid;
    logic                    w_fire;

    assign w_fire = r_valid & iREADY;
    assign oVALID = r_valid;
    assign oEMPTY = ~r_valid;
    assign oDATA  = r_hold[r_lane*D_BIT +: D_BIT];

    // The hold empties only after the final lane is handed off.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_hold  <= '0;
            r_lane  <= '0;
            r_valid <= 1'b0;
        end else if (iLOAD) begin
            r_hold  <= iWORDS;
            r_lane  <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            if (r_lane == LANE_LAST) begin
                r_lane  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fht_stream_ctrl.sv
// Streams ADC samples round-robin into the FHT core banks, starts the
// transform, then streams the results back out in natural index order.
module fht_stream_ctrl
    import fht_defines::*;
#(
    parameter int D_BIT  = DEF_D_BIT,
    parameter int A_BIT  = DEF_A_BIT,
    parameter int N_BANK = DEF_N_BANK,
    parameter int RD_LAT = DEF_RD_LAT
)(
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic [D_BIT-2:0]        iDATA,
    input  logic                    iVALID,
    output logic                    oREADY,
    output logic [D_BIT-1:0]        oCORE_DATA,
    output logic [A_BIT-1:0]        oCORE_ADDR_WR,
    output logic [N_BANK-1:0]       oCORE_WE,
    output logic                    oCORE_START,
    input  logic                    iCORE_RDY,
    output logic [N_BANK*A_BIT-1:0] oCORE_ADDR_RD,
    input  logic [N_BANK*D_BIT-1:0] iCORE_DATA,
    output logic [D_BIT-1:0]        oDATA,
    output logic                    oVALID,
    input  logic                    iREADY,
    output logic                    oLAST,
    output logic                    oBUSY
);
    localparam int LOG2B = $clog2(N_BANK);
    localparam int CW    = A_BIT + LOG2B;
    localparam logic [CW-1:0] IDX_LAST = '1;
    localparam logic [1:0]    LAT_LAST = 2'(RD_LAT);

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_wrCnt;
    logic [CW-1:0]       r_outIdx;
    logic [N_BANK-1:0]   r_we;
    logic [A_BIT-1:0]    r_addrWr;
    logic [D_BIT-1:0]    r_coreData;
    logic                r_start;
    logic [A_BIT:0]      r_rdIdx;
    logic                r_inFlight;
    logic [1:0]          r_latCnt;
    logic                w_ready;
    logic                w_accept;
    logic                w_issue;
    logic                w_capture;
    logic                w_outFire;
    logic                w_serValid;
    logic                w_holdEmpty;
    logic [N_BANK-1:0]   w_weOneHot;

    assign w_accept   = w_ready & iVALID;
    assign w_capture  = r_inFlight & (r_latCnt == LAT_LAST);
    assign w_outFire  = w_serValid & iREADY;
    assign w_weOneHot = {{(N_BANK-1){1'b0}}, 1'b1} << r_wrCnt[LOG2B-1:0];

    assign oREADY        = w_ready;
    assign oCORE_DATA    = r_coreData;
    assign oCORE_ADDR_WR = r_addrWr;
    assign oCORE_WE      = r_we;
    assign oCORE_START   = r_start;
    assign oCORE_ADDR_RD = (r_state == ST_UNLOAD) ? {N_BANK{r_rdIdx[A_BIT-1:0]}} : '0;
    assign oVALID        = w_serValid;
    assign oLAST         = w_serValid & (r_outIdx == IDX_LAST);
    assign oBUSY         = (r_state != ST_LOAD);

    // A new row read is issued only when the hold is empty and nothing is in flight.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_issue = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                w_ready = iCORE_RDY & iRESET;
                if (w_ready && iVALID && (r_wrCnt == IDX_LAST))
                    w_next = ST_START;
            end
            ST_START:     w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (!iCORE_RDY) w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (iCORE_RDY) w_next = ST_UNLOAD;
            ST_UNLOAD: begin
                w_issue = w_holdEmpty & ~r_inFlight & ~r_rdIdx[A_BIT];
                if (w_outFire && (r_outIdx == IDX_LAST))
                    w_next = ST_LOAD;
            end
            default: w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state    <= ST_LOAD;
            r_wrCnt    <= '0;
            r_outIdx   <= '0;
            r_we       <= '0;
            r_addrWr   <= '0;
            r_coreData <= '0;
            r_start    <= 1'b0;
            r_rdIdx    <= '0;
            r_inFlight <= 1'b0;
            r_latCnt   <= '0;
        end else begin
            r_state <= w_next;
            r_start <= (r_state == ST_START);
            r_we    <= '0;
            if (w_accept) begin
                r_we       <= w_weOneHot;
                r_addrWr   <= r_wrCnt[CW-1:LOG2B];
                r_coreData <= {iDATA[D_BIT-2], iDATA};
                r_wrCnt    <= r_wrCnt + 1'b1;
            end
            if (w_issue) begin
                r_inFlight <= 1'b1;
                r_latCnt   <= 2'd1;
            end else if (r_inFlight) begin
                if (w_capture) begin
                    r_inFlight <= 1'b0;
                    r_rdIdx    <= r_rdIdx + 1'b1;
                end else begin
                    r_latCnt <= r_latCnt + 1'b1;
                end
            end
            if (w_outFire)
                r_outIdx <= r_outIdx + 1'b1;
            if ((r_state == ST_UNLOAD) && (w_next == ST_LOAD))
                r_rdIdx <= '0;
        end
    end

    fht_stream_ser #(
        .D_BIT  (D_BIT),
        .N_BANK (N_BANK)
    ) u_ser (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iLOAD  (w_capture),
        .iWORDS (iCORE_DATA),
        .iREADY (iREADY),
        .oDATA  (oDATA),
        .oVALID (w_serValid),
        .oEMPTY (w_holdEmpty)
    );
endmodule
